// File: rtl/bus_protocol_monitor.sv
// Passive checker for the dValid/dAck single-master transfer protocol.
// Define BUS_PROTOCOL_DATA_CHECK_EN to build the data-stability check (err_pulse[5]).
module bus_protocol_monitor #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MIN_VALID = 2,
    parameter int unsigned MAX_VALID = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dValid,
    input  logic              dAck,
    input  logic [DATA_W-1:0] data,
    input  logic              clr,
    output logic [5:0]        err_pulse,
    output logic [5:0]        err_sticky,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);

    localparam int unsigned LEN_W = $clog2(MAX_VALID + 1);
    localparam logic [LEN_W-1:0] MinLen = LEN_W'(MIN_VALID);
    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_VALID);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StActive, StDrop, StRecover} state_e;

    state_e             state_q, state_d;
    logic               v_q, a_q;
    logic [LEN_W-1:0]   len_q, len_d, len_next;
    logic               err_seen_q, err_seen_d;
    logic [5:0]         err_pulse_q, err_pulse_d;
    logic [5:0]         err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               busy_q, busy_d;
    logic               rise_v, rise_a, data_mismatch, xfer_inc;

    assign rise_v   = dValid & ~v_q;
    assign rise_a   = dAck & ~a_q;
    assign len_next = len_q + 1'b1;

`ifdef BUS_PROTOCOL_DATA_CHECK_EN
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (state_q == StIdle && rise_v) begin
            data_d = data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_mismatch = (data != data_q);
`else
    logic unused_data;
    assign unused_data   = ^data;
    assign data_mismatch = 1'b0;
`endif

    // err_pulse_d bits: [0] short [1] long [2] ack_early [3] ack_missing [4] no_drop [5] data
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        err_seen_d  = err_seen_q;
        err_pulse_d = '0;
        xfer_inc    = 1'b0;
        case (state_q)
            StIdle: begin
                if (rise_v) begin
                    state_d        = StActive;
                    len_d          = LEN_W'(1);
                    err_pulse_d[2] = rise_a;
                    err_seen_d     = rise_a;
                end
            end
            StActive: begin
                err_pulse_d[5] = data_mismatch;
                if (dValid) begin
                    // len_next is the index of the current high cycle
                    len_d = len_next;
                    if (rise_a) begin
                        err_pulse_d[2] = (len_next < MinLen);
                        state_d        = StDrop;
                    end else if (len_next == MaxLen) begin
                        err_pulse_d[1] = 1'b1;
                        err_pulse_d[3] = 1'b1;
                        state_d        = StRecover;
                    end
                end else begin
                    err_pulse_d[3] = 1'b1;
                    err_pulse_d[0] = (len_q < MinLen);
                    state_d        = StIdle;
                end
                err_seen_d = err_seen_q | (|err_pulse_d);
            end
            StDrop: begin
                if (!dValid) begin
                    state_d  = StIdle;
                    xfer_inc = ~err_seen_q;
                end else begin
                    err_pulse_d[4] = 1'b1;
                    state_d        = StRecover;
                end
            end
            StRecover: begin
                if (!dValid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        err_sticky_d = err_sticky_q | err_pulse_d;
        xfer_cnt_d   = xfer_cnt_q;
        err_cnt_d    = err_cnt_q;
        if (xfer_inc && xfer_cnt_q != CntMax) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
        end
        if ((|err_pulse_d) && err_cnt_q != CntMax) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
        // clr wins over any same-cycle pulse
        if (clr) begin
            err_sticky_d = '0;
            xfer_cnt_d   = '0;
            err_cnt_d    = '0;
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            v_q          <= 1'b0;
            a_q          <= 1'b0;
            len_q        <= '0;
            err_seen_q   <= 1'b0;
            err_pulse_q  <= '0;
            err_sticky_q <= '0;
            xfer_cnt_q   <= '0;
            err_cnt_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            v_q          <= dValid;
            a_q          <= dAck;
            len_q        <= len_d;
            err_seen_q   <= err_seen_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            xfer_cnt_q   <= xfer_cnt_d;
            err_cnt_q    <= err_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign xfer_cnt   = xfer_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bus_protocol_monitor.sv
// Directed and randomized bench for bus_protocol_monitor against a per-transfer reference model.
module tb_bus_protocol_monitor;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MIN_VALID = 2;
    localparam int unsigned MAX_VALID = 4;
    localparam int unsigned CNT_W     = 4;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;
`ifdef BUS_PROTOCOL_DATA_CHECK_EN
    localparam bit DCHK = 1'b1;
`else
    localparam bit DCHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              dValid, dAck, clr;
    logic [DATA_W-1:0] data;
    logic [5:0]        err_pulse, err_sticky;
    logic [CNT_W-1:0]  xfer_cnt, err_cnt;
    logic              busy;

    int n_chk = 0;
    int n_bad = 0;

    bus_protocol_monitor #(
        .DATA_W    (DATA_W),
        .MIN_VALID (MIN_VALID),
        .MAX_VALID (MAX_VALID),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dValid     (dValid),
        .dAck       (dAck),
        .data       (data),
        .clr        (clr),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .xfer_cnt   (xfer_cnt),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: where we are within a transfer, and what it has seen so far.
    typedef enum int {MIdle, MBurst, MWaitDrop, MRecover} mphase_e;
    mphase_e     m_phase;
    int          m_hi;
    logic [7:0]  m_cap;
    bit          m_dirty, m_pv, m_pa;
    logic [5:0]  e_pulse, e_sticky;
    int          e_xfer, e_err;
    bit          e_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = MIdle; m_hi = 0; m_cap = '0; m_dirty = 0; m_pv = 0; m_pa = 0;
        e_pulse = '0; e_sticky = '0; e_xfer = 0; e_err = 0; e_busy = 0;
    endtask

    task automatic model_step(input bit v, input bit a, input logic [7:0] d, input bit c);
        bit rv, ra, clean_done;
        logic [5:0] fl;
        rv = v && !m_pv;
        ra = a && !m_pa;
        fl = '0;
        clean_done = 0;
        case (m_phase)
            MIdle: if (rv) begin
                m_phase = MBurst; m_hi = 1; m_cap = d;
                fl[2] = ra;
                m_dirty = ra;
            end
            MBurst: begin
                if (DCHK && d != m_cap) fl[5] = 1;
                if (v) begin
                    m_hi = m_hi + 1;
                    if (ra) begin
                        if (m_hi < MIN_VALID) fl[2] = 1;
                        m_phase = MWaitDrop;
                    end else if (m_hi == MAX_VALID) begin
                        fl[1] = 1; fl[3] = 1;
                        m_phase = MRecover;
                    end
                end else begin
                    fl[3] = 1;
                    if (m_hi < MIN_VALID) fl[0] = 1;
                    m_phase = MIdle;
                end
                if (fl != 0) m_dirty = 1;
            end
            MWaitDrop: if (!v) begin
                m_phase = MIdle;
                clean_done = !m_dirty;
            end else begin
                fl[4] = 1;
                m_phase = MRecover;
            end
            default: if (!v) m_phase = MIdle;
        endcase
        e_pulse = fl;
        if (c) begin
            e_sticky = '0; e_xfer = 0; e_err = 0;
        end else begin
            e_sticky = e_sticky | fl;
            if (clean_done && e_xfer < CNT_MAX) e_xfer++;
            if (fl != 0 && e_err < CNT_MAX) e_err++;
        end
        e_busy = (m_phase != MIdle);
        m_pv = v;
        m_pa = a;
    endtask

    task automatic compare_all();
        check("pulse",  32'(err_pulse),  32'(e_pulse));
        check("sticky", 32'(err_sticky), 32'(e_sticky));
        check("xfer",   32'(xfer_cnt),   32'(e_xfer));
        check("errcnt", 32'(err_cnt),    32'(e_err));
        check("busy",   32'(busy),       32'(e_busy));
    endtask

    task automatic cycle(input bit v, input bit a, input logic [7:0] d, input bit c);
        dValid = v; dAck = a; data = d; clr = c;
        model_step(v, a, d, c);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        bit v, a, c;
        logic [7:0] d;
        reset = 1'b1; dValid = 0; dAck = 0; data = '0; clr = 0;
        model_reset();
        #12;
        compare_all();
        @(posedge clk); #1;
        reset = 1'b0;

        // Clean three-cycle transfer
        cycle(1, 0, 8'h11, 0); cycle(1, 0, 8'h11, 0); cycle(1, 1, 8'h11, 0);
        check("clean_busy", 32'(busy), 32'd1);
        cycle(0, 0, 8'h11, 0);
        check("clean_xfer", 32'(xfer_cnt), 32'd1);
        check("clean_sticky", 32'(err_sticky), 32'd0);

        // dValid and dAck rise together
        cycle(0, 0, 8'h00, 1);
        cycle(1, 1, 8'h22, 0);
        check("early_pulse", 32'(err_pulse), 32'h04);
        cycle(1, 0, 8'h22, 0); cycle(1, 1, 8'h22, 0); cycle(0, 0, 8'h22, 0);
        check("early_errcnt", 32'(err_cnt), 32'd1);
        check("early_xfer", 32'(xfer_cnt), 32'd0);

        // Overlong transfer without dAck
        cycle(0, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) cycle(1, 0, 8'h33, 0);
        check("long_pulse", 32'(err_pulse), 32'h0a);
        cycle(1, 0, 8'h33, 0);
        check("long_recover_busy", 32'(busy), 32'd1);
        check("long_errcnt", 32'(err_cnt), 32'd1);
        cycle(0, 0, 8'h33, 0);
        check("long_idle", 32'(busy), 32'd0);

        // Data changes mid-transfer
        cycle(0, 0, 8'h00, 1);
        cycle(1, 0, 8'hA5, 0); cycle(1, 0, 8'h5A, 0);
        check("data_pulse", 32'(err_pulse[5]), 32'(DCHK));
        cycle(1, 1, 8'h5A, 0); cycle(0, 0, 8'h5A, 0);
        check("data_xfer", 32'(xfer_cnt), DCHK ? 32'd0 : 32'd1);

        // dValid still high after the ack cycle
        cycle(0, 0, 8'h00, 1);
        cycle(1, 0, 8'h44, 0); cycle(1, 1, 8'h44, 0); cycle(1, 0, 8'h44, 0);
        check("nodrop_pulse", 32'(err_pulse), 32'h10);
        cycle(0, 0, 8'h44, 0);
        check("nodrop_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-transfer
        cycle(1, 0, 8'h55, 0);
        dValid = 1; #2; reset = 1'b1; #1;
        model_reset();
        compare_all();
        #2; reset = 1'b0;
        cycle(1, 0, 8'h55, 0);
        check("reset_rise_busy", 32'(busy), 32'd1);
        cycle(1, 1, 8'h55, 0); cycle(0, 0, 8'h55, 0);

        // Randomized traffic, includes saturation of the narrow counters
        v = 0; a = 0; d = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 30) v = !v;
            if ($urandom_range(0, 99) < 25) a = !a;
            if ($urandom_range(0, 99) < 8)  d = 8'($urandom);
            c = ($urandom_range(0, 99) < 2);
            cycle(v, a, d, c);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
